// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: CHUNK bits per clock through one short carry chain,
// with a registered carry between chunks and valid/ready on both sides.
module chunked_add_sub #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   total,
  output logic         overflow
);

  localparam int STEPS = N / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_chunk
    $error("chunked_add_sub: N must be a multiple of CHUNK");
  end

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [N:0]    total_q, total_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic          ovf_q, ovf_d;

  logic [CHUNK:0] chunk;
  logic [N-1:0]   sum_sh;
  logic           msb_cin;
  logic           last;

  always_comb begin
    chunk = {1'b0, a_q[CHUNK-1:0]}
          + {1'b0, b_q[CHUNK-1:0]}
          + {{CHUNK{1'b0}}, carry_q};
    // New chunk enters at the top; after STEPS shifts it sits in place.
    sum_sh  = N'({chunk[CHUNK-1:0], sum_q} >> CHUNK);
    msb_cin = chunk[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
    last    = (cnt_q == CW'(STEPS - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          sub_d   = sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk[CHUNK];
        sum_d   = sum_sh;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          total_d = {sub_q ^ chunk[CHUNK], sum_sh};
          ovf_d   = msb_cin ^ chunk[CHUNK];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      total_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      total_q <= total_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign total     = total_q;
  assign overflow  = ovf_q;

endmodule
